// File: rtl/reaction_timer.sv
// Count-up reaction stopwatch: binary tick count plus an incrementally kept BCD copy.
// Define REACTION_TIMER_BEST_EN to build the best-time register; otherwise best_bcd is fixed at 16'h9999.
module reaction_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [13:0] elapsed,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done,
    output logic        overflow,
    output logic [15:0] best_bcd,
    output logic [1:0]  state_dbg
);
    localparam int DIV = CLOCK_FREQUENCY / TICK_HZ - 1;
    localparam int DW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [DW-1:0] DIV_V = DW'(DIV);
    localparam logic [13:0]   MAX_V = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [13:0]   elapsed_q, elapsed_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          tick, at_max, enter_run, stay_run;

    // Cascaded decade increment; a digit only advances when every lower digit wraps.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick      = (state_q == S_RUN) && (div_q == '0);
    assign at_max    = (elapsed_q == MAX_V);
    assign enter_run = (state_d == S_RUN) && (state_q != S_RUN);
    assign stay_run  = (state_d == S_RUN) && (state_q == S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // A tick at MAX_COUNT wins over a same-cycle stop: that tick has no room to be counted.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:         if (start) state_d = S_RUN;
                S_RUN: begin
                    if (tick && at_max) state_d = S_OVER;
                    else if (stop)      state_d = S_HOLD;
                end
                S_HOLD, S_OVER: if (start) state_d = S_RUN;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d  = (state_d == S_RUN);
        overflow_d = (state_d == S_OVER);
        done_d     = (state_q == S_RUN) && ((state_d == S_HOLD) || (state_d == S_OVER));
    end

    always_comb begin
        div_d     = DIV_V;
        elapsed_d = elapsed_q;
        bcd_d     = bcd_q;
        if (stay_run && !tick) div_d = div_q - DW'(1);
        if (clear || enter_run) begin
            elapsed_d = '0;
            bcd_d     = '0;
        end else if (tick && !at_max) begin
            elapsed_d = elapsed_q + 14'd1;
            bcd_d     = bcd_inc(bcd_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= DIV_V;
            elapsed_q  <= '0;
            bcd_q      <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            elapsed_q  <= elapsed_d;
            bcd_q      <= bcd_d;
            running_q  <= running_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef REACTION_TIMER_BEST_EN
    logic [15:0] best_q;
    // Packed BCD digits compare in the same order as their decimal values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) best_q <= 16'h9999;
        else if ((state_q == S_RUN) && (state_d == S_HOLD) && (bcd_d < best_q)) best_q <= bcd_d;
    end
    assign best_bcd = best_q;
`else
    assign best_bcd = 16'h9999;
`endif

    assign elapsed   = elapsed_q;
    assign bcd       = bcd_q;
    assign running   = running_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Count-up stopwatch that measures player reaction time in ticks of 1/TICK_HZ s, from a start pulse (prompt shown) to a stop pulse (player hit).
- Complements the countdown game timer. That timer limits the round; this block measures within it.
- Sits between the game FSM and the 7-segment path. It provides the binary elapsed count and a four-digit BCD copy kept incrementally, so no combinational binary-to-decimal stage is needed.

Parameters:
- CLOCK_FREQUENCY, 50000000, input clock in Hz.
- TICK_HZ, 100, count resolution in Hz (100 gives centiseconds).
- MAX_COUNT, 9999, saturation value; must be ≤ 9999.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a measurement.
- stop  in  1  one-cycle pulse that ends a measurement (player response).
- clear  in  1  synchronous return to IDLE with count zeroed.
- elapsed  out  14  binary tick count.
- bcd  out  16  four BCD digits of elapsed; [3:0] is the ones digit.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to HOLD or OVER.
- overflow  out  1  high in OVER.
- best_bcd  out  16  best (lowest) completed time in BCD; see Optional Feature.

Behaviour:
- Reset (async, immediate): state IDLE; elapsed=0, bcd=0, running=0, done=0, overflow=0, best_bcd=16'h9999; divider reloaded.
- Divider: DIV = CLOCK_FREQUENCY/TICK_HZ − 1, integer division.
  - Down-counter loads DIV when the block enters RUN.
  - In RUN it decrements each clk. At 0 it asserts tick for 1 cycle and reloads DIV.
  - The first tick comes DIV+1 cycles after entering RUN.
  - Outside RUN the divider holds at DIV.
- States: IDLE, RUN, HOLD, OVER.
- IDLE: start → RUN; elapsed and bcd cleared to 0 on the same edge. stop is ignored.
- RUN: on tick, elapsed += 1 and bcd increments as a cascaded decade counter (digit 9→0 carries to the next digit).
  - stop → HOLD on the next edge. A tick in the same cycle as stop is counted, so the held value includes it.
  - If a tick arrives while elapsed == MAX_COUNT → OVER. elapsed stays at MAX_COUNT and bcd at the matching digits. No wrap.
  - start in RUN is ignored; stop has priority.
- HOLD: elapsed and bcd are frozen. start → RUN (new measurement, counters zeroed). stop is ignored.
- OVER: overflow=1 and values frozen at MAX_COUNT. start → RUN with overflow dropping to 0. stop is ignored.
- clear: in any state, → IDLE next edge with elapsed=0, bcd=0. Overrides start and stop in the same cycle. Does not alter best_bcd.
- done: registered pulse, high exactly one cycle after the edge that enters HOLD or OVER.
- running: registered, equals (state==RUN).
- Invariant: bcd is always the decimal image of elapsed.

Optional Feature:
- Macro: REACTION_TIMER_BEST_EN.
- Defined: on entry to HOLD, if the final bcd < best_bcd (unsigned compare of the packed digits), best_bcd updates on the same edge that raises done. OVER never updates best_bcd. Only reset restores best_bcd to 16'h9999.
- Undefined: best_bcd is driven constant 16'h9999 and no compare logic or register is built.

Test Plan (CLOCK_FREQUENCY=1000, TICK_HZ=100, so DIV=9):
- Reset mid-RUN (elapsed=5) → all outputs return to reset values immediately, without a clock edge; state IDLE.
- start, then stop 35 cycles later → first tick at cycle 10; HOLD with elapsed=3, bcd=16'h0003; done high for 1 cycle; running=0.
- Run across a digit boundary: stop after 105 ticks → elapsed=105, bcd=16'h0105. Check every intermediate tick for bcd/elapsed agreement.
- MAX_COUNT=12: run 130 cycles → OVER at the 13th tick; elapsed=12, bcd=16'h0012, overflow=1, done pulse once. Then start → RUN, overflow=0, elapsed=0.
- stop coincident with the 4th tick → elapsed=4. start and clear in the same cycle from HOLD → IDLE, elapsed=0. start during RUN → ignored, count continues.
- With REACTION_TIMER_BEST_EN: three runs of 7, 3, and 5 ticks → best_bcd reads 16'h0007, then 16'h0003, then stays 16'h0003. Without the macro → best_bcd constant 16'h9999.
